// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - clock-enable scheduler: pixel enable plus programmable game-step tick
//
// Purpose: single-clock-domain enable generator. pix_en pulses every PIX_DIV
// cycles. tick pulses once per programmed period while running, or once per
// step request. The period is reconfigured through a valid/ready handshake and
// takes effect without truncating or stretching an interval already in flight.
//
// Ports:
//   clk         in   1      system clock, all logic on posedge
//   rst_n       in   1      synchronous active-low reset
//   run         in   1      level, 1 = tick continuously
//   step        in   1      pulse, in IDLE produce exactly one tick
//   cfg_valid   in   1      new period offered
//   cfg_period  in   CNT_W  offered period in cycles (0 treated as 1)
//   cfg_ready   out  1      no period update pending
//   pix_en      out  1      1-cycle pulse every PIX_DIV cycles
//   tick        out  1      1-cycle game-step pulse
//   tick_cnt    out  16     ticks issued since reset (wraps)
//   state       out  2      00 IDLE, 01 RUN, 10 STEP

module tick_scheduler #(
    parameter int CNT_W          = 27,
    parameter int DEFAULT_PERIOD = 100000000,
    parameter int PIX_DIV        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_ready,
    output logic             pix_en,
    output logic             tick,
    output logic [15:0]      tick_cnt,
    output logic [1:0]       state
);

    localparam int PIX_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic               tick_q, tick_d;
    logic [15:0]        tick_cnt_q, tick_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               pix_en_q, pix_en_d;
    logic               terminal;
    logic               pix_last;

    // period_q is never 0, so period_q-1 cannot underflow.
    assign terminal = (cnt_q == period_q - CNT_W'(1));
    assign pix_last = (pix_cnt_q == PIX_W'(PIX_DIV - 1));

    // State register (all registered state lives here)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= CNT_W'(DEFAULT_PERIOD);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
            pix_cnt_q  <= '0;
            pix_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            pix_en_q   <= pix_en_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        period_d   = period_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run)       state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            S_RUN: begin
                // Dropping run beats a terminal count on the same edge.
                if (!run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (terminal) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STEP: begin
                // Runs to completion; run/step are ignored until back in IDLE.
                if (terminal) begin
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A pending period is only swapped in at an interval boundary: any edge
        // while idle, or the edge that issues a tick while counting.
        if (pend_q) begin
            if (state_q == S_IDLE || tick_d) begin
                period_d = pend_val_q;
                pend_d   = 1'b0;
            end
        end else if (cfg_valid) begin
            pend_d     = 1'b1;
            pend_val_d = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
        end

        tick_cnt_d = tick_d ? tick_cnt_q + 16'd1 : tick_cnt_q;
        pix_cnt_d  = pix_last ? '0 : pix_cnt_q + PIX_W'(1);
        pix_en_d   = pix_last;
    end

    // Output logic
    always_comb begin
        cfg_ready = ~pend_q;
        pix_en    = pix_en_q;
        tick      = tick_q;
        tick_cnt  = tick_cnt_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - self-checking bench for tick_scheduler

module tb_tick_scheduler;

    localparam int CNT_W   = 27;
    localparam int DEF_P   = 5;
    localparam int PIX_DIV = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             step;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_ready;
    logic             pix_en;
    logic             tick;
    logic [15:0]      tick_cnt;
    logic [1:0]       state;

    tick_scheduler #(
        .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P), .PIX_DIV(PIX_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .cfg_valid(cfg_valid), .cfg_period(cfg_period), .cfg_ready(cfg_ready),
        .pix_en(pix_en), .tick(tick), .tick_cnt(tick_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rst_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rst_cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fails  = 0;
    bit pix_on   = 1'b0;
    bit sb_on    = 1'b0;
    int sb_q[$];

    typedef struct {
        logic             run;
        logic             step;
        logic             cv;
        logic [CNT_W-1:0] cp;
        logic             e_tick;
        logic [15:0]      e_tc;
        logic [1:0]       e_state;
        logic             e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic cv, int cp,
                                logic et, int etc, logic [1:0] es, logic er);
        vec_t v;
        v.run = r; v.step = s; v.cv = cv; v.cp = CNT_W'(cp);
        v.e_tick = et; v.e_tc = 16'(etc); v.e_state = es; v.e_rdy = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge, then run the continuous monitors.
    task automatic tick_clk();
        logic exp_pix;
        int   exp_t;
        @(negedge clk);
        if (pix_on) begin
            exp_pix = (cyc > rst_cyc) && (((cyc - rst_cyc) % PIX_DIV) == 0);
            chk("pix_en", 32'(pix_en), 32'(exp_pix));
        end
        if (sb_on) begin
            while (sb_q.size() > 0 && sb_q[0] < cyc) begin
                chk("missing_tick", 32'(cyc), 32'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (tick === 1'b1) begin
                exp_t = (sb_q.size() > 0) ? sb_q[0] : -1;
                chk("tick_time", 32'(cyc), 32'(exp_t));
                if (sb_q.size() > 0 && sb_q[0] == cyc) void'(sb_q.pop_front());
            end
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick_clk();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick_clk();
        tick_clk();
        rst_n = 1'b1;
    endtask

    task automatic set_period(input int p);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        tick_clk();
        chk("cfg_ready_pend", 32'(cfg_ready), 32'd0);
        cfg_valid  = 1'b0;
        tick_clk();
        chk("cfg_ready_idle_apply", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; cfg_valid = 1'b0; cfg_period = '0;

        // Expected post-edge values with DEFAULT_PERIOD=5.
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 0, 0, (i % 5 == 0) && (i > 0), i / 5, 2'b01, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2'b00, 1));
        tbl.push_back(mk(0, 0, 1, 4, 0, 3, 2'b00, 0));   // accept period 4
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2'b00, 1));   // applied in IDLE
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 2'b10, 1));   // step -> STEP
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 2'b10, 1));   // ignored in STEP
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2'b10, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2'b10, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 2'b00, 1));   // tick 4 after entry
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 2'b00, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4, 2'b01, 1));   // run wins
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 2'b00, 1));

        tick_clk();
        tick_clk();
        pix_on = 1'b1;
        tick_clk();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_tick_cnt", 32'(tick_cnt), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;

        // T1 / T3 table
        foreach (tbl[i]) begin
            run = tbl[i].run; step = tbl[i].step;
            cfg_valid = tbl[i].cv; cfg_period = tbl[i].cp;
            tick_clk();
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].e_tick));
            chk($sformatf("vec%0d_tick_cnt", i), 32'(tick_cnt), 32'(tbl[i].e_tc));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            chk($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].e_rdy));
        end
        run = 1'b0; step = 1'b0; cfg_valid = 1'b0;

        // T2: reconfigure to 3 mid-interval
        set_period(5);
        sb_on = 1'b1;
        c = cyc;
        run = 1'b1;
        sb_q.push_back(c + 6); sb_q.push_back(c + 9); sb_q.push_back(c + 12);
        wait_to(c + 2);
        cfg_valid = 1'b1; cfg_period = CNT_W'(3);
        tick_clk();
        chk("t2_ready_low", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        wait_to(c + 5);
        chk("t2_ready_still_low", 32'(cfg_ready), 32'd0);
        tick_clk();
        chk("t2_ready_after_tick", 32'(cfg_ready), 32'd1);
        wait_to(c + 12);
        run = 1'b0;
        tick_clk();
        chk("t2_state", 32'(state), 32'd0);
        chk("t2_tick_cnt", 32'(tick_cnt), 32'd7);

        // T4: stop on terminal count suppresses the tick
        set_period(5);
        c = cyc;
        run = 1'b1;
        wait_to(c + 5);
        run = 1'b0;
        tick_clk();
        chk("t4_state", 32'(state), 32'd0);
        chk("t4_tick_cnt", 32'(tick_cnt), 32'd7);
        c = cyc;
        run = 1'b1;
        sb_q.push_back(c + 6);
        wait_to(c + 6);
        run = 1'b0;
        tick_clk();
        chk("t4_rerun_tick_cnt", 32'(tick_cnt), 32'd8);

        // T3: single step, then silence for 20 cycles
        c = cyc;
        step = 1'b1;
        sb_q.push_back(c + 6);
        tick_clk();
        step = 1'b0;
        chk("t3_state_step", 32'(state), 32'd2);
        wait_to(c + 6);
        chk("t3_state_idle", 32'(state), 32'd0);
        wait_to(c + 26);
        chk("t3_tick_cnt", 32'(tick_cnt), 32'd9);

        // T5: period 0 -> 1, tick every cycle, tick_cnt wrap
        do_reset();
        set_period(0);
        run = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            sb_q.push_back(cyc + 2);
            tick_clk();
        end
        chk("t5_tick_cnt_ffff", 32'(tick_cnt), 32'hFFFF);
        tick_clk();
        chk("t5_tick_cnt_wrap", 32'(tick_cnt), 32'd0);
        run = 1'b0;
        tick_clk();
        chk("t5_state", 32'(state), 32'd0);

        // T6: reset mid-RUN with pending config
        sb_on = 1'b0;
        set_period(5);
        run = 1'b1;
        tick_clk();
        tick_clk();
        cfg_valid = 1'b1; cfg_period = CNT_W'(7);
        tick_clk();
        chk("t6_pending", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        run = 1'b0;
        rst_n = 1'b0;
        tick_clk();
        chk("t6_state", 32'(state), 32'd0);
        chk("t6_tick", 32'(tick), 32'd0);
        chk("t6_tick_cnt", 32'(tick_cnt), 32'd0);
        chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("t6_pix_en", 32'(pix_en), 32'd0);
        rst_n = 1'b1;
        tick_clk();
        sb_on = 1'b1;
        c = cyc;
        run = 1'b1;
        sb_q.push_back(c + 6);
        wait_to(c + 8);
        run = 1'b0;
        tick_clk();
        chk("t6_tick_cnt_after", 32'(tick_cnt), 32'd1);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
